// File: rtl/ram_sweep_ctrl.sv
// Write/read-back sweep controller for a single-port synchronous RAM.
// Writes P(a) = SEED ^ a to every address, reads everything back and reports mismatches.
module ram_sweep_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1,
   parameter logic [DATA_W-1:0] SEED = 16'hA5C3
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   output logic              ram_rden,
   input  logic [DATA_W-1:0] ram_q,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [2:0]        fsm_state
);

   localparam int CNT_W = ADDR_W + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state;
   logic [1:0]        drain_cnt;
   logic              pipe_vld  [RD_LAT];
   logic [ADDR_W-1:0] pipe_addr [RD_LAT];
   logic              out_vld;
   logic [ADDR_W-1:0] out_addr;
   logic              mismatch;
   logic              last_addr;

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
      return SEED ^ DATA_W'(a);
   endfunction

   assign fsm_state = state;
   assign out_vld   = pipe_vld[RD_LAT-1];
   assign out_addr  = pipe_addr[RD_LAT-1];
   assign mismatch  = out_vld && (ram_q != pattern(out_addr));
   assign last_addr = (ram_addr == {ADDR_W{1'b1}});

   // Each issued read travels alongside its address until the RAM returns its data.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_vld[i]  <= 1'b0;
            pipe_addr[i] <= '0;
         end
      end else begin
         pipe_vld[0]  <= ram_rden;
         pipe_addr[0] <= ram_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state          <= S_IDLE;
         drain_cnt      <= '0;
         ram_addr       <= '0;
         ram_data       <= '0;
         ram_wren       <= 1'b0;
         ram_rden       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         done <= 1'b0;
         if (mismatch) begin
            err_count <= err_count + CNT_W'(1);
            if (err_count == '0) first_err_addr <= out_addr;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  state          <= S_WRITE;
                  busy           <= 1'b1;
                  pass           <= 1'b0;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  ram_wren       <= 1'b1;
                  ram_addr       <= '0;
                  ram_data       <= pattern('0);
               end
            end
            S_WRITE: begin
               if (last_addr) begin
                  state    <= S_READ;
                  ram_wren <= 1'b0;
                  ram_rden <= 1'b1;
                  ram_addr <= '0;
               end else begin
                  ram_addr <= ram_addr + ADDR_W'(1);
                  ram_data <= pattern(ram_addr + ADDR_W'(1));
               end
            end
            S_READ: begin
               if (last_addr) begin
                  state     <= S_DRAIN;
                  ram_rden  <= 1'b0;
                  ram_addr  <= '0;
                  drain_cnt <= '0;
               end else begin
                  ram_addr <= ram_addr + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               // The last read's data is compared on the edge that leaves DRAIN.
               if (drain_cnt == 2'(RD_LAT - 1)) state <= S_DONE;
               else drain_cnt <= drain_cnt + 2'd1;
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               pass  <= (err_count == '0);
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Bench for ram_sweep_ctrl: two builds (RD_LAT 1 and 2), each on a behavioural RAM with
// injectable read faults; expected results come from a per-address pattern model.
module tb_ram_sweep_ctrl;

   localparam logic [15:0] SEED = 16'hA5C3;

   logic Clk, Reset;
   logic start1, start2;
   logic [7:0]  a1, a2, f1, f2;
   logic [15:0] d1, d2, q1, q2;
   logic w1, w2, r1, r2, busy1, busy2, done1, done2, pass1, pass2;
   logic [8:0]  e1, e2;
   logic [2:0]  st1, st2;

   ram_sweep_ctrl #(.RD_LAT(1)) u_d1 (
      .Clk(Clk), .Reset(Reset), .start(start1), .ram_addr(a1), .ram_data(d1),
      .ram_wren(w1), .ram_rden(r1), .ram_q(q1), .busy(busy1), .done(done1),
      .pass(pass1), .err_count(e1), .first_err_addr(f1), .fsm_state(st1));

   ram_sweep_ctrl #(.RD_LAT(2)) u_d2 (
      .Clk(Clk), .Reset(Reset), .start(start2), .ram_addr(a2), .ram_data(d2),
      .ram_wren(w2), .ram_rden(r2), .ram_q(q2), .busy(busy2), .done(done2),
      .pass(pass2), .err_count(e2), .first_err_addr(f2), .fsm_state(st2));

   // clock / reset
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // RAM fault configuration: 0 none, 1 stuck bit, 2 xor mask on selected addresses
   int          fault_mode;
   int          stuck_bit;
   logic        stuck_val;
   logic [15:0] bad_mask;
   logic        bad [256];

   function automatic logic [15:0] ram_fault(input logic [7:0] a, input logic [15:0] d);
      logic [15:0] r;
      r = d;
      if (fault_mode == 1) r[stuck_bit] = stuck_val;
      else if (fault_mode == 2 && bad[a]) r = d ^ bad_mask;
      return r;
   endfunction

   logic [15:0] mem1 [256];
   logic [15:0] mem2 [256];
   logic [15:0] q1_s1, q2_s1, q2_s2;

   always @(posedge Clk) begin
      if (w1) mem1[a1] <= d1;
      if (r1) q1_s1 <= ram_fault(a1, mem1[a1]);
      if (w2) mem2[a2] <= d2;
      if (r2) q2_s1 <= ram_fault(a2, mem2[a2]);
      q2_s2 <= q2_s1;
   end
   assign q1 = q1_s1;
   assign q2 = q2_s2;

   // selected DUT view
   logic        sel;
   logic        m_wren, m_rden, m_busy, m_done, m_pass;
   logic [7:0]  m_addr, m_first;
   logic [15:0] m_data;
   logic [8:0]  m_err;
   assign m_wren  = sel ? w2 : w1;
   assign m_rden  = sel ? r2 : r1;
   assign m_busy  = sel ? busy2 : busy1;
   assign m_done  = sel ? done2 : done1;
   assign m_pass  = sel ? pass2 : pass1;
   assign m_addr  = sel ? a2 : a1;
   assign m_first = sel ? f2 : f1;
   assign m_data  = sel ? d2 : d1;
   assign m_err   = sel ? e2 : e1;

   // bus monitor: address order, write data, overlap, done pulses
   int wr_tot, bad_wr_tot, rd_tot, bad_rd_tot, ovl_tot, done_tot, wr_idx, rd_idx;
   initial begin
      wr_tot = 0; bad_wr_tot = 0; rd_tot = 0; bad_rd_tot = 0;
      ovl_tot = 0; done_tot = 0; wr_idx = 0; rd_idx = 0;
   end

   always @(posedge Clk) begin
      if ((w1 && r1) || (w2 && r2)) ovl_tot++;
      if (m_done) done_tot++;
      if (!m_busy) begin
         wr_idx = 0;
         rd_idx = 0;
      end else begin
         if (m_wren) begin
            if (m_addr !== 8'(wr_idx) || m_data !== (SEED ^ {8'h00, m_addr})) bad_wr_tot++;
            wr_idx++;
            wr_tot++;
         end
         if (m_rden) begin
            if (m_addr !== 8'(rd_idx)) bad_rd_tot++;
            rd_idx++;
            rd_tot++;
         end
      end
   end

   // scoreboard
   int n_cmp, n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference: what a full sweep should report given the RAM fault setup
   task automatic model(output int exp_err, output int exp_first);
      logic [15:0] exp_q[$];
      logic [15:0] p;
      exp_err = 0;
      exp_first = 0;
      for (int a = 0; a < 256; a++) exp_q.push_back(SEED ^ 16'(a));
      for (int a = 0; a < 256; a++) begin
         p = exp_q.pop_front();
         if (ram_fault(8'(a), p) !== p) begin
            if (exp_err == 0) exp_first = a;
            exp_err++;
         end
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start2 = v;
      else start1 = v;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 32'({m_addr, m_data, m_wren, m_rden, m_busy, m_done, m_pass}), 32'd0);
      chk({tag, "_err"}, 32'({m_err, m_first}), 32'd0);
   endtask

   task automatic run_sweep(input string tag, input bit repulse, input int exp_err,
                            input int exp_first);
      int lat, b_wr, b_bw, b_rd, b_br, b_dn, bad_mem;
      logic [15:0] mv;
      b_wr = wr_tot; b_bw = bad_wr_tot; b_rd = rd_tot; b_br = bad_rd_tot; b_dn = done_tot;
      @(negedge Clk);
      set_start(1'b1);
      @(posedge Clk);
      #1;
      set_start(1'b0);
      chk({tag, "_busy"}, 32'(m_busy), 32'd1);
      lat = 0;
      while (lat < 3000) begin
         @(posedge Clk);
         lat++;
         #1;
         if (m_done) break;
         set_start(repulse && (lat == 10 || lat == 300));
      end
      set_start(1'b0);
      chk({tag, "_latency"}, 32'(lat), 32'(2 * 256 + (sel ? 2 : 1) + 1));
      chk({tag, "_done"}, 32'(m_done), 32'd1);
      chk({tag, "_busy_at_done"}, 32'(m_busy), 32'd0);
      chk({tag, "_pass"}, 32'(m_pass), 32'(exp_err == 0));
      chk({tag, "_err_count"}, 32'(m_err), 32'(exp_err));
      chk({tag, "_first_err"}, 32'(m_first), 32'(exp_first));
      @(posedge Clk);
      #1;
      chk({tag, "_done_fell"}, 32'(m_done), 32'd0);
      chk({tag, "_pass_held"}, 32'(m_pass), 32'(exp_err == 0));
      chk({tag, "_done_pulses"}, 32'(done_tot - b_dn), 32'd1);
      chk({tag, "_writes"}, 32'(wr_tot - b_wr), 32'd256);
      chk({tag, "_reads"}, 32'(rd_tot - b_rd), 32'd256);
      chk({tag, "_bus_order"}, 32'((bad_wr_tot - b_bw) + (bad_rd_tot - b_br)), 32'd0);
      bad_mem = 0;
      for (int a = 0; a < 256; a++) begin
         mv = sel ? mem2[a] : mem1[a];
         if (mv !== (SEED ^ 16'(a))) bad_mem++;
      end
      chk({tag, "_ram_contents"}, 32'(bad_mem), 32'd0);
   endtask

   task automatic clear_faults();
      fault_mode = 0;
      for (int a = 0; a < 256; a++) bad[a] = 1'b0;
   endtask

   initial begin
      int ee, ef, n;
      n_cmp = 0;
      n_fail = 0;
      Reset = 1'b1;
      start1 = 1'b0;
      start2 = 1'b0;
      sel = 1'b0;
      stuck_bit = 0;
      stuck_val = 1'b0;
      bad_mask = 16'h0001;
      clear_faults();
      repeat (3) @(posedge Clk);
      #1;
      chk_zero("reset_d1");
      sel = 1'b1;
      #1;
      chk_zero("reset_d2");
      sel = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;

      // ideal RAM, RD_LAT=1
      model(ee, ef);
      run_sweep("ideal", 1'b0, ee, ef);
      chk("ideal_q5", 32'(mem1[5]), 32'h0000A5C6);

      // bit 0 stuck at 0
      fault_mode = 1; stuck_bit = 0; stuck_val = 1'b0;
      model(ee, ef);
      run_sweep("stuck0", 1'b0, ee, ef);

      // single corrupted address
      clear_faults();
      fault_mode = 2; bad[8'h7F] = 1'b1; bad_mask = 16'($urandom_range(1, 16'hFFFF));
      model(ee, ef);
      run_sweep("addr7f", 1'b0, ee, ef);

      // start re-pulsed mid-sweep
      clear_faults();
      run_sweep("repulse", 1'b1, 0, 0);

      // reset during the write phase at address 40
      @(negedge Clk);
      start1 = 1'b1;
      @(posedge Clk);
      #1;
      start1 = 1'b0;
      n = 0;
      while (n < 1000 && !(m_wren && m_addr == 8'd40)) begin
         @(posedge Clk);
         n++;
         #1;
      end
      chk("reset_reached_addr40", 32'(m_addr), 32'd40);
      Reset = 1'b1;
      #1;
      chk_zero("reset_mid");
      @(negedge Clk);
      Reset = 1'b0;
      run_sweep("after_reset", 1'b0, 0, 0);

      // randomized fault scenarios on either build
      for (int r = 0; r < 4; r++) begin
         clear_faults();
         sel = 1'($urandom_range(0, 1));
         fault_mode = $urandom_range(0, 2);
         stuck_bit = $urandom_range(0, 15);
         stuck_val = 1'($urandom_range(0, 1));
         bad_mask = 16'($urandom_range(1, 16'hFFFF));
         for (int a = 0; a < 256; a++) bad[a] = ($urandom_range(0, 15) == 0);
         model(ee, ef);
         repeat ($urandom_range(1, 5)) @(posedge Clk);
         run_sweep($sformatf("rand%0d", r), 1'b0, ee, ef);
      end

      // every address wrong: counter must reach DEPTH without wrapping
      clear_faults();
      sel = 1'b0;
      fault_mode = 2;
      bad_mask = 16'($urandom_range(1, 16'hFFFF));
      for (int a = 0; a < 256; a++) bad[a] = 1'b1;
      model(ee, ef);
      run_sweep("all_bad", 1'b0, ee, ef);

      // RD_LAT=2 build, ideal RAM
      clear_faults();
      sel = 1'b1;
      run_sweep("lat2", 1'b0, 0, 0);
      chk("lat2_q5", 32'(mem2[5]), 32'h0000A5C6);

      chk("wren_rden_overlap", 32'(ovl_tot), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
